hiscore_bridge: RTL and testbench

HISCORE_BRIDGE -- requirements
Module: hiscore_bridge

---
 rtl/hiscore_bridge_pkg.sv | 23 ++
 rtl/hiscore_pause_timer.sv | 50 +++++
 rtl/hiscore_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_hiscore_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : hiscore_bridge_pkg                                               |
// | Purpose  : Shared types and constants for the high-score NVRAM bridge.      |
// |            Holds the bridge FSM state encoding and the default data_io      |
// |            index that selects a high-score transfer.                        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package hiscore_bridge_pkg;

   // Bridge FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_XFER    = 2'd2,
      ST_RELEASE = 2'd3
   } hs_state_e;

   // data_io index used for high-score load/save unless overridden
   localparam logic [7:0] HS_INDEX_DEFAULT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/hiscore_pause_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : hiscore_pause_timer                                              |
// | Purpose  : Down-counter that measures how long the core is held before the  |
// |            bridge starts touching the RAM.                                  |
// | Ports    : clk_sys  - system clock                                          |
// |            reset    - asynchronous active-high reset                        |
// |            load     - restart the count (PAUSE_CYC cycles until done)       |
// |            en       - count down one step this cycle                        |
// |            done     - high while the count has reached zero                 |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module hiscore_pause_timer #(
   parameter int PAUSE_CYC = 16
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int               CNT_W    = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
   // Loading PAUSE_CYC-1 makes done rise on the PAUSE_CYC-th enabled cycle
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PAUSE_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/hiscore_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : hiscore_bridge                                                   |
// | Purpose  : Moves the high-score NVRAM image between the data_io transfer    |
// |            bus and a dual-port RAM, pausing the core CPU while it owns the  |
// |            RAM port and tracking whether the RAM was modified by the core.  |
// | Ports    : clk_sys, reset            - clock, async active-high reset       |
// |            ioctl_*                   - data_io download/upload bus          |
// |            core_pause / core_we      - core hold and core write strobe      |
// |            ram_addr/din/we/dout      - bridge-side RAM port (read lat. 1)   |
// |            dirty, checksum, busy     - status                               |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module hiscore_bridge
   import hiscore_bridge_pkg::*;
#(
   parameter int         ADDR_W    = 6,
   parameter logic [7:0] HS_INDEX  = HS_INDEX_DEFAULT,
   parameter int         PAUSE_CYC = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic [7:0]        ioctl_din,
   output logic              core_pause,
   input  logic              core_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_we,
   input  logic [7:0]        ram_dout,
   output logic              dirty,
   output logic [7:0]        checksum,
   output logic              busy
);

   hs_state_e         state_q, state_d;
   logic              active_q;
   logic              core_pause_q, core_pause_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_din_q, ram_din_d;
   logic [7:0]        checksum_q, checksum_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [7:0]        pend_data_q, pend_data_d;
   logic              dirty_q, dirty_d;
   logic              rd_q, rd_d;
   logic              oor_q, oor_d;
   logic [7:0]        ioctl_din_q, ioctl_din_d;

   logic              active;
   logic              active_rise;
   logic              is_dl;
   logic              is_ul;
   logic              in_range;
   logic              timer_load;
   logic              timer_done;

   assign active      = (ioctl_download | ioctl_upload) && (ioctl_index == HS_INDEX);
   assign active_rise = active & ~active_q;
   // Download takes precedence when both directions are asserted
   assign is_dl       = ioctl_download;
   assign is_ul       = ioctl_upload & ~ioctl_download;
   assign in_range    = ((ioctl_addr >> ADDR_W) == 25'd0);

   hiscore_pause_timer #(
      .PAUSE_CYC (PAUSE_CYC)
   ) u_pause_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .load    (timer_load),
      .en      (state_q == ST_HOLD),
      .done    (timer_done)
   );

   always_comb begin
      state_d      = state_q;
      core_pause_d = core_pause_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      checksum_d   = checksum_q;
      pend_d       = pend_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      rd_d         = 1'b0;
      oor_d        = oor_q;
      timer_load   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (active_rise) begin
               state_d      = ST_HOLD;
               core_pause_d = 1'b1;
               checksum_d   = 8'h00;
               pend_d       = 1'b0;
               timer_load   = 1'b1;
            end
         end
         ST_HOLD: begin
            // The core may still be finishing a RAM access, so an early write
            // is parked here (newest wins) and replayed once the hold expires.
            if (ioctl_wr && is_dl && in_range) begin
               pend_d      = 1'b1;
               pend_addr_d = ioctl_addr[ADDR_W-1:0];
               pend_data_d = ioctl_dout;
            end
            if (timer_done) begin
               state_d    = ST_XFER;
               ram_we_d   = pend_d;
               ram_addr_d = pend_addr_d;
               ram_din_d  = pend_data_d;
               if (pend_d) begin
                  checksum_d = checksum_q + pend_data_d;
               end
               pend_d = 1'b0;
            end
         end
         ST_XFER: begin
            if (!active) begin
               state_d      = ST_RELEASE;
               core_pause_d = 1'b0;
            end else if (is_dl) begin
               if (ioctl_wr && in_range) begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = ioctl_addr[ADDR_W-1:0];
                  ram_din_d  = ioctl_dout;
                  checksum_d = checksum_q + ioctl_dout;
               end
            end else begin
               // Upload: the address goes straight to the RAM this cycle;
               // remember that a read is in flight and whether it is out of range.
               rd_d  = 1'b1;
               oor_d = ~in_range;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // RAM data returns one cycle after the address; register it for data_io
      ioctl_din_d = ioctl_din_q;
      if (rd_q) begin
         ioctl_din_d = oor_q ? 8'h00 : ram_dout;
      end

      // The clear is applied during RELEASE (core already running again), so a
      // core write landing in that same cycle is not lost.
      dirty_d = dirty_q;
      if (core_we && !core_pause_q) begin
         dirty_d = 1'b1;
      end else if (state_q == ST_RELEASE) begin
         dirty_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         // Treat the bus as already active so a transfer still running across
         // reset is not mistaken for a fresh start.
         active_q     <= 1'b1;
         core_pause_q <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= 8'h00;
         checksum_q   <= 8'h00;
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= 8'h00;
         dirty_q      <= 1'b0;
         rd_q         <= 1'b0;
         oor_q        <= 1'b0;
         ioctl_din_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         active_q     <= active;
         core_pause_q <= core_pause_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         checksum_q   <= checksum_d;
         pend_q       <= pend_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         dirty_q      <= dirty_d;
         rd_q         <= rd_d;
         oor_q        <= oor_d;
         ioctl_din_q  <= ioctl_din_d;
      end
   end

   // Upload reads bypass the address register to meet the two-cycle read path
   assign ram_addr   = ((state_q == ST_XFER) && is_ul) ? ioctl_addr[ADDR_W-1:0] : ram_addr_q;
   assign ram_din    = ram_din_q;
   assign ram_we     = ram_we_q;
   assign core_pause = core_pause_q;
   assign dirty      = dirty_q;
   assign checksum   = checksum_q;
   assign ioctl_din  = ioctl_din_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hiscore_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_hiscore_bridge                                                |
// | Purpose  : Directed self-checking bench for hiscore_bridge with a 64-byte   |
// |            synchronous-read RAM model on the bridge port.                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_hiscore_bridge;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download, ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_din;
   logic        core_pause;
   logic        core_we;
   logic [5:0]  ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;
   logic        dirty;
   logic [7:0]  checksum;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;

   logic [7:0] mem [0:63];

   always #5 clk_sys = ~clk_sys;

   hiscore_bridge #(
      .ADDR_W    (6),
      .HS_INDEX  (8'hFF),
      .PAUSE_CYC (16)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_upload   (ioctl_upload),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_din      (ioctl_din),
      .core_pause     (core_pause),
      .core_we        (core_we),
      .ram_addr       (ram_addr),
      .ram_din        (ram_din),
      .ram_we         (ram_we),
      .ram_dout       (ram_dout),
      .dirty          (dirty),
      .checksum       (checksum),
      .busy           (busy)
   );

   // RAM model: write-first not needed, one-cycle registered read
   always @(posedge clk_sys) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         we_cnt        <= we_cnt + 1;
      end
      ram_dout <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         seen;
      int         base;
      int         bad;
      logic [7:0] exp_din;

      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      reset = 1'b1;
      ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'h00;
      ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00; core_we = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_core_pause", 32'(core_pause), 32'd0);
      check("rst_ram_we",     32'(ram_we),     32'd0);
      check("rst_dirty",      32'(dirty),      32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_checksum",   32'(checksum),   32'd0);
      check("rst_ioctl_din",  32'(ioctl_din),  32'd0);
      check("rst_ram_addr",   32'(ram_addr),   32'd0);
      reset = 1'b0;
      tick(); tick();

      // core write while running marks the NVRAM dirty
      core_we = 1'b1; tick(); core_we = 1'b0;
      check("dirty_set_idle", 32'(dirty), 32'd1);

      // Download at a foreign index is ignored entirely
      seen = 0;
      ioctl_index = 8'h00; ioctl_download = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h55;
         tick();
         seen = seen | int'({ram_we, core_pause, busy});
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0; tick();
      check("foreign_idx_quiet", 32'(seen), 32'd0);

      // Download 64 bytes 0x01..0x40
      ioctl_index = 8'hFF; ioctl_download = 1'b1;
      tick();
      check("dl_pause_on_hold", 32'(core_pause), 32'd1);
      check("dl_busy_hold",     32'(busy),       32'd1);
      check("dl_checksum_clr",  32'(checksum),   32'd0);
      for (int i = 0; i < 20; i++) tick();
      base = we_cnt;
      for (int i = 0; i < 64; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1); ioctl_wr = 1'b1;
         tick();
         ioctl_wr = 1'b0;
         tick();
      end
      ioctl_addr = 25'd64; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;  // beyond depth, dropped
      tick(); ioctl_wr = 1'b0; tick();
      ioctl_download = 1'b0;
      tick();
      check("dl_pause_off_release", 32'(core_pause), 32'd0);
      check("dl_busy_release",      32'(busy),       32'd1);
      tick();
      check("dl_busy_idle",   32'(busy),          32'd0);
      check("dl_we_count",    32'(we_cnt - base), 32'd64);
      check("dl_checksum",    32'(checksum),      32'h20);
      check("dl_dirty_clr",   32'(dirty),         32'd0);
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i + 1)) bad++;
      check("dl_ram_pattern", 32'(bad), 32'd0);

      // Upload the image back; dirty set beforehand must clear afterwards
      core_we = 1'b1; tick(); core_we = 1'b0;
      ioctl_upload = 1'b1; ioctl_addr = 25'd0;
      tick();
      for (int i = 0; i < 20; i++) tick();
      base = we_cnt;
      for (int a = 0; a <= 64; a++) begin
         ioctl_addr = 25'(a);
         tick(); tick();
         exp_din = (a < 64) ? 8'(a + 1) : 8'h00;
         check($sformatf("ul_din_a%0d", a), 32'(ioctl_din), 32'(exp_din));
      end
      check("ul_no_we", 32'(we_cnt - base), 32'd0);
      ioctl_upload = 1'b0;
      tick();
      check("ul_pause_off", 32'(core_pause), 32'd0);
      tick();
      check("ul_dirty_clr", 32'(dirty), 32'd0);

      // core write coinciding with the RELEASE cycle keeps dirty set
      core_we = 1'b1; tick(); core_we = 1'b0;
      ioctl_upload = 1'b1; ioctl_addr = 25'd0;
      for (int i = 0; i < 20; i++) tick();
      ioctl_upload = 1'b0;
      tick();  // now in RELEASE
      check("rel_busy", 32'(busy), 32'd1);
      core_we = 1'b1; tick(); core_we = 1'b0;
      check("rel_dirty_kept", 32'(dirty), 32'd1);
      tick();
      check("rel_dirty_kept2", 32'(dirty), 32'd1);

      // Write during the 3rd HOLD cycle is replayed on the first XFER cycle
      ioctl_download = 1'b1; ioctl_addr = 25'd0;
      tick(); tick(); tick();  // HOLD cycle 3
      base = we_cnt;
      ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'hAA;
      tick();
      ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      check("hold_no_we_early", 32'(ram_we), 32'd0);
      tick();
      check("hold_we_xfer1", 32'(ram_we),   32'd1);
      check("hold_we_addr",  32'(ram_addr), 32'd5);
      check("hold_we_data",  32'(ram_din),  32'hAA);
      tick();
      check("hold_we_single", 32'(we_cnt - base), 32'd1);
      check("hold_checksum",  32'(checksum),      32'hAA);

      // Reset in the middle of a download at byte 10
      for (int i = 0; i < 10; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = 8'h30; ioctl_wr = 1'b1;
         tick();
         ioctl_wr = 1'b0;
         tick();
      end
      ioctl_addr = 25'd10; ioctl_dout = 8'h31; ioctl_wr = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_outputs",
            32'({core_pause, ram_we, dirty, busy, checksum, ioctl_din, ram_addr}), 32'd0);
      tick();
      reset = 1'b0;
      base = we_cnt;
      seen = 0;
      for (int i = 11; i < 21; i++) begin
         ioctl_addr = 25'(i); ioctl_wr = 1'b1;
         tick();
         ioctl_wr = 1'b0;
         tick();
         seen = seen | int'({core_pause, busy});
      end
      check("post_rst_no_we",  32'(we_cnt - base), 32'd0);
      check("post_rst_idle",   32'(seen),          32'd0);

      // A new edge restarts; core writes while paused do not mark dirty
      ioctl_download = 1'b0; tick();
      ioctl_download = 1'b1; tick();
      check("restart_busy", 32'(busy), 32'd1);
      core_we = 1'b1; tick(); core_we = 1'b0;
      check("paused_core_we_ignored", 32'(dirty), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      ioctl_download = 1'b0;
      tick(); tick();
      check("restart_done_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
